fetch_ir_unit: RTL and testbench

- Upstream fetch stage of the multi-cycle RISC-V core.
- Owns the PC register and the instruction register (IR), and runs the instruction-memory read handshake with variable latency.
- Presents `opcode` and `complete_inst` to the controller.
- Applies the controller's PC-update controls (PCWrite, PCWriteCond, PCSource) and raises a stall while a fetch is outstanding.

---
 rtl/fetch_ir_unit.sv | 214 +++++++++++++++++++++
 tb/tb_fetch_ir_unit.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ir_unit.sv
// ----------------------------------------------------------------------------
// fetch_ir_unit
//
// Upstream fetch stage of the multi-cycle RISC-V core. Owns the program
// counter and the instruction register (IR). Runs the instruction-memory read
// handshake, which has a variable latency, and presents the fetched word to
// the controller. Also applies the controller's PC-update controls.
//
// Memory handshake: in IDLE, a fetch_req raises mem_rd and captures mem_addr
// from pc. mem_rd and mem_addr then stay stable until one of two things
// happens. Either mem_ack is seen (mem_rdata is valid in that same cycle), or
// TIMEOUT WAIT cycles pass without an ack, which moves the unit to ERR.
// mem_ack is only meaningful while in WAIT and is ignored elsewhere.
//
// Ports:
//   clk, rst        : rising-edge clock, synchronous active-high reset
//   fetch_req       : controller asks for an instruction fetch
//   pcWrite         : unconditional PC write enable
//   PCWriteCond     : PC write enable, qualified by zero
//   zero            : ALU zero flag
//   PCSource        : next-PC select (00 alu_result, 01 alu_out, 10 pc+4,
//                     11 reserved/hold)
//   alu_result      : combinational ALU result
//   alu_out         : registered ALUOut
//   mem_addr        : instruction-memory read address
//   mem_rd          : read request, held until acknowledged
//   mem_ack         : memory acknowledge
//   mem_rdata       : instruction word from memory
//   pc              : current PC
//   complete_inst   : IR contents
//   opcode          : complete_inst[6:0]
//   inst_valid      : one-cycle pulse, IR updated this cycle
//   fetch_busy      : stall, high while a fetch is outstanding
//   fetch_err       : sticky fetch-timeout error
//   state_dbg       : current FSM state (0 IDLE, 1 WAIT, 2 ERR)
// ----------------------------------------------------------------------------
module fetch_ir_unit #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter int              TIMEOUT  = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fetch_req,
    input  logic            pcWrite,
    input  logic            PCWriteCond,
    input  logic            zero,
    input  logic [1:0]      PCSource,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] alu_out,
    output logic [XLEN-1:0] mem_addr,
    output logic            mem_rd,
    input  logic            mem_ack,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] complete_inst,
    output logic [6:0]      opcode,
    output logic            inst_valid,
    output logic            fetch_busy,
    output logic            fetch_err,
    output logic [1:0]      state_dbg
);

    // The counter only needs to reach TIMEOUT-1.
    localparam int            CW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
    localparam logic [XLEN-1:0] ALIGN_MSK = ~XLEN'(3);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;
    logic [CW-1:0]   wait_cnt;
    logic [XLEN-1:0] ir;

    logic            fetch_start;
    logic            ack_take;
    logic            timeout_hit;
    logic            pc_en;
    logic            pc_load;
    logic [XLEN-1:0] pc_cand;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state and handshake events
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        fetch_start = 1'b0;
        ack_take    = 1'b0;
        timeout_hit = 1'b0;
        case (state)
            ST_IDLE: begin
                // mem_ack is ignored here, which also drops stale acks
                // that show up right after a reset.
                if (fetch_req) begin
                    fetch_start = 1'b1;
                    state_next  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // An ack takes priority over the timeout, so an ack in the
                // TIMEOUT-th WAIT cycle is still accepted.
                if (mem_ack) begin
                    ack_take   = 1'b1;
                    state_next = ST_IDLE;
                end else if (wait_cnt == CNT_LAST) begin
                    timeout_hit = 1'b1;
                    state_next  = ST_ERR;
                end
            end
            ST_ERR: begin
                state_next = ST_ERR;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshake datapath: address, request, counter, IR, status flags
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_addr   <= '0;
            mem_rd     <= 1'b0;
            wait_cnt   <= '0;
            ir         <= '0;
            inst_valid <= 1'b0;
            fetch_err  <= 1'b0;
        end else begin
            inst_valid <= 1'b0;
            if (fetch_start) begin
                // mem_addr is captured once and is not affected by later PC
                // writes while this fetch is outstanding.
                mem_addr <= pc;
                mem_rd   <= 1'b1;
                wait_cnt <= '0;
            end else if (ack_take) begin
                ir         <= mem_rdata;
                inst_valid <= 1'b1;
                mem_rd     <= 1'b0;
            end else if (timeout_hit) begin
                mem_rd    <= 1'b0;
                fetch_err <= 1'b1;
            end else if (state == ST_WAIT) begin
                wait_cnt <= wait_cnt + CW'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // PC update
    // ------------------------------------------------------------------
    assign pc_en = pcWrite | (PCWriteCond & zero);

    always_comb begin
        pc_cand = pc;
        pc_load = 1'b0;
        case (PCSource)
            2'b00: begin
                pc_cand = alu_result;
                pc_load = pc_en;
            end
            2'b01: begin
                pc_cand = alu_out;
                pc_load = pc_en;
            end
            2'b10: begin
                pc_cand = pc + PC_STEP;
                pc_load = pc_en;
            end
            default: begin
                // Reserved encoding: the PC holds even when enabled.
                pc_cand = pc;
                pc_load = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
        end else if (pc_load && (state != ST_ERR)) begin
            // The written PC is always word aligned.
            pc <= pc_cand & ALIGN_MSK;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign fetch_busy    = (state == ST_WAIT);
    assign complete_inst = ir;
    assign opcode        = ir[6:0];
    assign state_dbg     = state;

endmodule

// File: tb/tb_fetch_ir_unit.sv
// ----------------------------------------------------------------------------
// tb_fetch_ir_unit
//
// Directed bench for fetch_ir_unit. A table of PC-update vectors is applied
// in a loop. Hand-written sequences cover the fetch handshake, a PC write
// during an outstanding fetch, an ack on the last allowed WAIT cycle, the
// timeout/ERR path, and reset in the middle of a fetch.
// ----------------------------------------------------------------------------
module tb_fetch_ir_unit;

  localparam int XLEN    = 32;
  localparam int TIMEOUT = 15;

  logic            clk;
  logic            rst;
  logic            fetch_req;
  logic            pcWrite;
  logic            PCWriteCond;
  logic            zero;
  logic [1:0]      PCSource;
  logic [XLEN-1:0] alu_result;
  logic [XLEN-1:0] alu_out;
  logic [XLEN-1:0] mem_addr;
  logic            mem_rd;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] complete_inst;
  logic [6:0]      opcode;
  logic            inst_valid;
  logic            fetch_busy;
  logic            fetch_err;
  logic [1:0]      state_dbg;

  int n_compared;
  int n_mismatched;

  fetch_ir_unit #(
    .XLEN(XLEN),
    .RESET_PC(32'h0000_0000),
    .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_req(fetch_req),
    .pcWrite(pcWrite),
    .PCWriteCond(PCWriteCond),
    .zero(zero),
    .PCSource(PCSource),
    .alu_result(alu_result),
    .alu_out(alu_out),
    .mem_addr(mem_addr),
    .mem_rd(mem_rd),
    .mem_ack(mem_ack),
    .mem_rdata(mem_rdata),
    .pc(pc),
    .complete_inst(complete_inst),
    .opcode(opcode),
    .inst_valid(inst_valid),
    .fetch_busy(fetch_busy),
    .fetch_err(fetch_err),
    .state_dbg(state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // PC-update vector table
  typedef struct {
    logic        pw;
    logic        pwc;
    logic        z;
    logic [1:0]  src;
    logic [31:0] ar;
    logic [31:0] ao;
    logic [31:0] exp_pc;
  } pc_vec_t;

  pc_vec_t vecs[9];

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  task automatic clear_pc_ctrl();
    pcWrite     = 1'b0;
    PCWriteCond = 1'b0;
    zero        = 1'b0;
    PCSource    = 2'b00;
  endtask

  initial begin
    int cnt;
    int guard;

    n_compared   = 0;
    n_mismatched = 0;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'hFFFF_FFFE, 32'h0000_0000, 32'hFFFF_FFFC};
    vecs[1] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0000};
    vecs[2] = '{1'b1, 1'b0, 1'b0, 2'b00, 32'h0000_0107, 32'h0000_0000, 32'h0000_0104};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 2'b01, 32'h0000_0000, 32'h0000_0040, 32'h0000_0104};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 2'b01, 32'h0000_0000, 32'h0000_0040, 32'h0000_0040};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 2'b11, 32'h0000_0999, 32'h0000_0777, 32'h0000_0040};
    vecs[6] = '{1'b0, 1'b0, 1'b1, 2'b00, 32'h0000_0500, 32'h0000_0000, 32'h0000_0040};
    vecs[7] = '{1'b1, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0000_0000, 32'h0000_0044};
    vecs[8] = '{1'b1, 1'b0, 1'b0, 2'b01, 32'h0000_0000, 32'h0000_0013, 32'h0000_0010};

    rst        = 1'b1;
    fetch_req  = 1'b0;
    mem_ack    = 1'b0;
    mem_rdata  = '0;
    alu_result = '0;
    alu_out    = '0;
    clear_pc_ctrl();

    // ---- reset state
    step();
    step();
    check("rst_pc", pc, 32'h0);
    check("rst_opcode", {25'd0, opcode}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("rst_inst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    check("rst_fetch_busy", {31'd0, fetch_busy}, 32'd0);
    rst = 1'b0;

    // ---- basic fetch, ack on the second WAIT cycle
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("f1_mem_rd_c1", {31'd0, mem_rd}, 32'd1);
    check("f1_mem_addr", mem_addr, 32'h0);
    check("f1_busy_c1", {31'd0, fetch_busy}, 32'd1);
    check("f1_iv_c1", {31'd0, inst_valid}, 32'd0);
    step();
    check("f1_mem_rd_c2", {31'd0, mem_rd}, 32'd1);
    check("f1_busy_c2", {31'd0, fetch_busy}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0033;
    step();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    check("f1_opcode", {25'd0, opcode}, 32'h33);
    check("f1_inst", complete_inst, 32'h0000_0033);
    check("f1_iv_pulse", {31'd0, inst_valid}, 32'd1);
    check("f1_mem_rd_drop", {31'd0, mem_rd}, 32'd0);
    check("f1_busy_drop", {31'd0, fetch_busy}, 32'd0);
    step();
    check("f1_iv_end", {31'd0, inst_valid}, 32'd0);
    check("f1_opcode_hold", {25'd0, opcode}, 32'h33);

    // ---- PC update table
    for (int i = 0; i < 9; i++) begin
      pcWrite     = vecs[i].pw;
      PCWriteCond = vecs[i].pwc;
      zero        = vecs[i].z;
      PCSource    = vecs[i].src;
      alu_result  = vecs[i].ar;
      alu_out     = vecs[i].ao;
      step();
      check($sformatf("vec%0d_pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d_mem_rd", i), {31'd0, mem_rd}, 32'd0);
    end
    clear_pc_ctrl();
    alu_result = '0;
    alu_out    = '0;

    // ---- PC write during WAIT keeps mem_addr of the outstanding fetch
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("pw_mem_addr_start", mem_addr, 32'h10);
    pcWrite  = 1'b1;
    PCSource = 2'b10;
    step();
    clear_pc_ctrl();
    check("pw_pc_in_wait", pc, 32'h14);
    check("pw_mem_addr_held", mem_addr, 32'h10);
    check("pw_busy", {31'd0, fetch_busy}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h00A0_0093;
    step();
    mem_ack   = 1'b0;
    check("pw_inst", complete_inst, 32'h00A0_0093);
    check("pw_mem_addr_after", mem_addr, 32'h10);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    check("pw_next_addr", mem_addr, 32'h14);
    // ack and PC write in the same cycle
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_006F;
    pcWrite   = 1'b1;
    PCSource  = 2'b10;
    step();
    mem_ack = 1'b0;
    clear_pc_ctrl();
    check("both_opcode", {25'd0, opcode}, 32'h6F);
    check("both_pc", pc, 32'h18);
    check("both_iv", {31'd0, inst_valid}, 32'd1);

    // ---- ack on the last allowed WAIT cycle is accepted
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    for (int i = 0; i < TIMEOUT - 1; i++) step();
    check("late_still_waiting", {31'd0, mem_rd}, 32'd1);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_1037;
    step();
    mem_ack = 1'b0;
    check("late_iv", {31'd0, inst_valid}, 32'd1);
    check("late_opcode", {25'd0, opcode}, 32'h37);
    check("late_no_err", {31'd0, fetch_err}, 32'd0);

    // ---- timeout into ERR
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    cnt   = 0;
    guard = 0;
    while (mem_rd && guard < 40) begin
      cnt++;
      guard++;
      step();
    end
    check("to_mem_rd_cycles", cnt, TIMEOUT);
    check("to_err", {31'd0, fetch_err}, 32'd1);
    check("to_busy", {31'd0, fetch_busy}, 32'd0);
    fetch_req = 1'b1;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0013;
    pcWrite   = 1'b1;
    PCSource  = 2'b10;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("err%0d_sticky", i), {31'd0, fetch_err}, 32'd1);
      check($sformatf("err%0d_mem_rd", i), {31'd0, mem_rd}, 32'd0);
      check($sformatf("err%0d_iv", i), {31'd0, inst_valid}, 32'd0);
      check($sformatf("err%0d_opcode", i), {25'd0, opcode}, 32'h37);
      check($sformatf("err%0d_pc", i), pc, 32'h18);
    end
    fetch_req = 1'b0;
    mem_ack   = 1'b0;
    clear_pc_ctrl();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("err_rst_flag", {31'd0, fetch_err}, 32'd0);
    check("err_rst_pc", pc, 32'h0);
    check("err_rst_opcode", {25'd0, opcode}, 32'h0);

    // ---- reset in the middle of WAIT, stale ack afterwards
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0017;
    step();
    mem_ack = 1'b0;
    check("mid_pre_opcode", {25'd0, opcode}, 32'h17);
    fetch_req = 1'b1;
    step();
    fetch_req = 1'b0;
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    check("mid_rst_opcode", {25'd0, opcode}, 32'h0);
    check("mid_rst_busy", {31'd0, fetch_busy}, 32'd0);
    mem_ack   = 1'b1;
    mem_rdata = 32'h0000_0003;
    step();
    mem_ack = 1'b0;
    check("stale_opcode", {25'd0, opcode}, 32'h0);
    check("stale_iv", {31'd0, inst_valid}, 32'd0);
    check("stale_busy", {31'd0, fetch_busy}, 32'd0);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
